sad_min_tracker: RTL and testbench

Streaming minimum-SAD selector for the motion-estimation datapath. It accepts candidate SADs as LANES-wide beats over a valid/ready handshake and tracks the running minimum and its candidate index across a block of N_CAND candidates. It then presents the winning SAD and index on a valid/ready output port. It sits between the SAD accumulator array and the motion-vector decision logic. It generalises the fixed five-input combinational minimum finder to any candidate count, lane width and SAD width.

---
 rtl/sad_pkg.sv | 16 +
 rtl/sad_min_tree.sv | 53 +++++
 rtl/sad_min_tracker.sv | 106 ++++++++++
 tb/tb_sad_min_tracker.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sad_pkg.sv
// rtl/sad_pkg.sv - shared constants, types and helpers for the minimum-SAD selector.
package sad_pkg;

  localparam int SAD_W_DEF = 14;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } sad_state_e;

  // Index width for n items; a single item still needs one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sad_min_tree.sv
// rtl/sad_min_tree.sv - combinational balanced-tree reduction of LANES SADs to (min, lane).
// Ties resolve to the lower lane at every node.
module sad_min_tree
  import sad_pkg::*;
#(
  parameter int  SAD_W = SAD_W_DEF,
  parameter int  LANES = 4,
  localparam int LW    = idx_w(LANES)
) (
  input  logic [LANES*SAD_W-1:0] sad_i,
  output logic [SAD_W-1:0]       min_o,
  output logic [LW-1:0]          lane_o
);

  generate
    if (LANES == 1) begin : g_leaf
      assign min_o  = sad_i;
      assign lane_o = '0;
    end else begin : g_node
      localparam int NLO = LANES / 2;
      localparam int NHI = LANES - NLO;

      logic [SAD_W-1:0]      lo_min;
      logic [SAD_W-1:0]      hi_min;
      logic [idx_w(NLO)-1:0] lo_lane;
      logic [idx_w(NHI)-1:0] hi_lane;

      sad_min_tree #(.SAD_W(SAD_W), .LANES(NLO)) u_lo (
        .sad_i  (sad_i[NLO*SAD_W-1:0]),
        .min_o  (lo_min),
        .lane_o (lo_lane)
      );

      sad_min_tree #(.SAD_W(SAD_W), .LANES(NHI)) u_hi (
        .sad_i  (sad_i[LANES*SAD_W-1:NLO*SAD_W]),
        .min_o  (hi_min),
        .lane_o (hi_lane)
      );

      // Upper half wins only on strictly smaller SAD.
      always_comb begin
        if (hi_min < lo_min) begin
          min_o  = hi_min;
          lane_o = LW'(NLO) + LW'(hi_lane);
        end else begin
          min_o  = lo_min;
          lane_o = LW'(lo_lane);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/sad_min_tracker.sv
// rtl/sad_min_tracker.sv - streaming minimum-SAD selector over blocks of N_CAND candidates.
// Accepts LANES candidates per beat and presents the block winner on a valid/ready port.
module sad_min_tracker
  import sad_pkg::*;
#(
  parameter int  SAD_W  = SAD_W_DEF,
  parameter int  LANES  = 4,
  parameter int  N_CAND = 16,
  localparam int IDX_W  = idx_w(N_CAND)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*SAD_W-1:0] in_sad,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SAD_W-1:0]       out_sad,
  output logic [IDX_W-1:0]       out_idx
);

  localparam int BEATS = N_CAND / LANES;
  localparam int BW    = idx_w(BEATS);
  localparam int LW    = idx_w(LANES);

  sad_state_e       state_q, state_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [SAD_W-1:0] best_sad_q, best_sad_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [SAD_W-1:0] out_sad_q, out_sad_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;

  logic [SAD_W-1:0] tree_min;
  logic [LW-1:0]    tree_lane;
  logic [IDX_W-1:0] gidx;

  sad_min_tree #(.SAD_W(SAD_W), .LANES(LANES)) u_tree (
    .sad_i  (in_sad),
    .min_o  (tree_min),
    .lane_o (tree_lane)
  );

  assign gidx = IDX_W'(beat_q) * IDX_W'(LANES) + IDX_W'(tree_lane);

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    best_sad_d = best_sad_q;
    best_idx_d = best_idx_q;
    out_sad_d  = out_sad_q;
    out_idx_d  = out_idx_q;
    if (clr) begin
      state_d = ST_ACC;
      beat_d  = '0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (in_valid) begin
            // First beat always reloads, so stale minima never leak across blocks.
            if (beat_q == '0 || tree_min < best_sad_q) begin
              best_sad_d = tree_min;
              best_idx_d = gidx;
            end
            if (beat_q == BW'(BEATS - 1)) begin
              state_d   = ST_DONE;
              beat_d    = '0;
              out_sad_d = best_sad_d;
              out_idx_d = best_idx_d;
            end else begin
              beat_d = beat_q + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) state_d = ST_ACC;
        end
        default: state_d = ST_ACC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ACC;
      beat_q     <= '0;
      best_sad_q <= '0;
      best_idx_q <= '0;
      out_sad_q  <= '0;
      out_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      best_sad_q <= best_sad_d;
      best_idx_q <= best_idx_d;
      out_sad_q  <= out_sad_d;
      out_idx_q  <= out_idx_d;
    end
  end

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_DONE);
  assign out_sad   = out_sad_q;
  assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_sad_min_tracker.sv
// tb/tb_sad_min_tracker.sv - scoreboard bench for sad_min_tracker (4x16 and 5x5 configurations).
module tb_sad_min_tracker;

  localparam int SW = 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic [4*SW-1:0] in_sad = '0;
  logic          out_ready = 1'b1;
  logic          in_ready, out_valid;
  logic [SW-1:0] out_sad;
  logic [3:0]    out_idx;

  logic          clr5 = 1'b0;
  logic          in_valid5 = 1'b0;
  logic [5*SW-1:0] in_sad5 = '0;
  logic          out_ready5 = 1'b1;
  logic          in_ready5, out_valid5;
  logic [SW-1:0] out_sad5;
  logic [2:0]    out_idx5;

  int vectors = 0;
  int errors  = 0;
  bit gaps    = 1'b0;
  logic [17:0] q[$];
  logic [16:0] q5[$];

  sad_min_tracker u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_sad(in_sad), .out_valid(out_valid), .out_ready(out_ready),
    .out_sad(out_sad), .out_idx(out_idx)
  );

  sad_min_tracker #(.SAD_W(SW), .LANES(5), .N_CAND(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .clr(clr5), .in_valid(in_valid5), .in_ready(in_ready5),
    .in_sad(in_sad5), .out_valid(out_valid5), .out_ready(out_ready5),
    .out_sad(out_sad5), .out_idx(out_idx5)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      vectors++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected: got sad=%0d idx=%0d, none expected", out_sad, out_idx);
      end else begin
        logic [17:0] e;
        e = q.pop_front();
        if ({out_idx, out_sad} !== e) begin
          errors++;
          $display("FAIL result4: got sad=%0d idx=%0d, want sad=%0d idx=%0d",
                   out_sad, out_idx, e[13:0], e[17:14]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid5 && out_ready5) begin
      vectors++;
      if (q5.size() == 0) begin
        errors++;
        $display("FAIL result5_unexpected: got sad=%0d idx=%0d", out_sad5, out_idx5);
      end else begin
        logic [16:0] e;
        e = q5.pop_front();
        if ({out_idx5, out_sad5} !== e) begin
          errors++;
          $display("FAIL result5: got sad=%0d idx=%0d, want sad=%0d idx=%0d",
                   out_sad5, out_idx5, e[13:0], e[16:14]);
        end
      end
    end
  end

  function automatic logic [17:0] model(input logic [16*SW-1:0] blk);
    logic [SW-1:0] best;
    logic [3:0]    idx;
    best = blk[SW-1:0];
    idx  = 4'd0;
    for (int i = 1; i < 16; i++) begin
      if (blk[i*SW +: SW] < best) begin
        best = blk[i*SW +: SW];
        idx  = 4'(i);
      end
    end
    return {idx, best};
  endfunction

  function automatic logic [16*SW-1:0] pack16(input int v[16]);
    logic [16*SW-1:0] b;
    for (int i = 0; i < 16; i++) b[i*SW +: SW] = SW'(v[i]);
    return b;
  endfunction

  function automatic logic [16*SW-1:0] rand_blk(input int hi);
    logic [16*SW-1:0] b;
    for (int i = 0; i < 16; i++) b[i*SW +: SW] = SW'($urandom_range(0, hi));
    return b;
  endfunction

  task automatic put_beat(input logic [4*SW-1:0] d);
    int n = 0;
    if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_sad   = d;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin
      vectors++;
      errors++;
      $display("FAIL beat_timeout: in_ready=%0b after %0d cycles, want 1", in_ready, n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [16*SW-1:0] blk, input bit push);
    if (push) q.push_back(model(blk));
    for (int b = 0; b < 4; b++) put_beat(blk[b*4*SW +: 4*SW]);
    if (push) begin
      vectors++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL latency: out_valid=%0b one cycle after last beat, want 1", out_valid);
      end
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q.size() != 0 || q5.size() != 0) && n < 200) begin @(posedge clk); #1; n++; end
    vectors++;
    if (n >= 200) begin
      errors++;
      $display("FAIL drain_timeout: %0d/%0d results pending, want 0", q.size(), q5.size());
      q.delete();
      q5.delete();
    end
  endtask

  task automatic check_idle(input string name);
    vectors++;
    if (out_valid !== 1'b0 || out_sad !== '0 || out_idx !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: valid=%0b sad=%0d idx=%0d ready=%0b, want 0 0 0 1",
               name, out_valid, out_sad, out_idx, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset_asserted");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle("reset_released");
    vectors++;
    if (out_valid5 !== 1'b0 || in_ready5 !== 1'b1 || out_sad5 !== '0 || out_idx5 !== '0) begin
      errors++;
      $display("FAIL reset5: valid=%0b ready=%0b sad=%0d idx=%0d, want 0 1 0 0",
               out_valid5, in_ready5, out_sad5, out_idx5);
    end
  endtask

  task automatic test_basic();
    int v[16] = '{100, 90, 80, 95, 70, 70, 200, 300, 71, 500, 600, 700, 900, 800, 75, 70};
    logic [16*SW-1:0] blk;
    blk = pack16(v);
    vectors++;
    if (model(blk) !== {4'd4, 14'd70}) begin
      errors++;
      $display("FAIL basic_model: got %0h, want sad=70 idx=4", model(blk));
    end
    send_block(blk, 1'b1);
    wait_drain();
  endtask

  task automatic put5(input logic [5*SW-1:0] d, input logic [16:0] e);
    int n = 0;
    q5.push_back(e);
    in_valid5 = 1'b1;
    in_sad5   = d;
    while (!in_ready5 && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid5 = 1'b0;
    vectors++;
    if (n >= 50 || out_valid5 !== 1'b1) begin
      errors++;
      $display("FAIL lanes5_latency: out_valid=%0b wait=%0d, want 1", out_valid5, n);
    end
  endtask

  task automatic test_lanes5();
    put5({14'd5, 14'd6, 14'd7, 14'd8, 14'd9}, {3'd4, 14'd5});
    put5({14'd3, 14'd3, 14'd3, 14'd3, 14'd3}, {3'd0, 14'd3});
    put5({14'd1, 14'd0, 14'd2, 14'd0, 14'd9}, {3'd1, 14'd0});
    wait_drain();
  endtask

  task automatic test_extremes();
    logic [16*SW-1:0] blk;
    blk = '1;
    q.push_back({4'd0, 14'd16383});
    send_block(blk, 1'b0);
    blk[15*SW +: SW] = '0;
    q.push_back({4'd15, 14'd0});
    send_block(blk, 1'b0);
    wait_drain();
  endtask

  task automatic test_backpressure();
    logic [17:0] e;
    out_ready = 1'b0;
    send_block(rand_blk(16383), 1'b1);
    e = q[0];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {out_idx, out_sad} !== e) begin
        errors++;
        $display("FAIL hold_c%0d: valid=%0b ready=%0b sad=%0d idx=%0d, want 1 0 %0d %0d",
                 c, out_valid, in_ready, out_sad, out_idx, e[13:0], e[17:14]);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || q.size() != 0) begin
      errors++;
      $display("FAIL release: ready=%0b valid=%0b pending=%0d, want 1 0 0",
               in_ready, out_valid, q.size());
    end
  endtask

  task automatic test_gaps();
    logic [16*SW-1:0] blk;
    for (int r = 0; r < 4; r++) begin
      blk = rand_blk((r < 2) ? 3 : 16383);
      gaps = 1'b0;
      send_block(blk, 1'b1);
      gaps = 1'b1;
      send_block(blk, 1'b1);
    end
    gaps = 1'b0;
    wait_drain();
  endtask

  task automatic test_clr();
    logic [16*SW-1:0] blk;
    blk = rand_blk(5);
    for (int b = 0; b < 2; b++) put_beat(blk[b*4*SW +: 4*SW]);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    for (int i = 0; i < 16; i++) blk[i*SW +: SW] = SW'($urandom_range(43, 16383));
    blk[9*SW +: SW] = SW'(42);
    q.push_back({4'd9, 14'd42});
    send_block(blk, 1'b0);
    wait_drain();

    blk = rand_blk(100);
    for (int b = 0; b < 3; b++) put_beat(blk[b*4*SW +: 4*SW]);
    in_valid = 1'b1;
    in_sad   = blk[3*4*SW +: 4*SW];
    clr      = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    clr      = 1'b0;
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL clr_last_c%0d: valid=%0b ready=%0b, want 0 1", c, out_valid, in_ready);
      end
      @(posedge clk); #1;
    end
    send_block(rand_blk(16383), 1'b1);
    wait_drain();
  endtask

  task automatic test_async_reset();
    logic [16*SW-1:0] blk;
    blk = rand_blk(50);
    blk[0 +: SW] = '0;
    for (int b = 0; b < 2; b++) put_beat(blk[b*4*SW +: 4*SW]);
    #2 rst_n = 1'b0;
    #1 check_idle("reset_midblock");
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_block(rand_blk(16383) | {(16*SW){1'b0}}, 1'b1);
    wait_drain();

    out_ready = 1'b0;
    blk = rand_blk(16383);
    blk[7*SW +: SW] = SW'(1);
    send_block(blk, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1 check_idle("reset_done");
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send_block(rand_blk(16383), 1'b1);
    wait_drain();
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) send_block(rand_blk((r % 2) ? 16383 : 7), 1'b1);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lanes5();
    test_extremes();
    test_backpressure();
    test_gaps();
    test_clr();
    test_async_reset();
    test_random();
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
